// File: rtl/demux_dispatcher.sv
// demux_dispatcher: buffers source words in a small FIFO and issues one word
// per cycle to the 8-way output demux, with a 3-bit channel select chosen by
// round-robin bursts over enabled channels or by a per-word destination tag.
// Optional feature macro: DEMUX_DISPATCH_DROP_CNT_EN builds the saturating
// counter of words discarded in directed mode; without it drop_cnt_o is 0.
module demux_dispatcher #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic [2:0]            in_dest_i,
   input  logic                  mode_i,
   input  logic [7:0]            chan_en_i,
   output logic [2:0]            selector_o,
   output logic [DATA_WIDTH-1:0] channel_o,
   output logic                  strobe_o,
   output logic                  busy_o,
   output logic [7:0]            drop_cnt_o
);

   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam int              CW        = AW + 1;
   localparam int              EW        = DATA_WIDTH + 3;
   localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [8:0]      BURST_MAX = 9'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t          state;

   // FIFO storage: each entry holds {dest, data}
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;

   logic            push;
   logic            pop;
   logic [DATA_WIDTH-1:0] head_data;
   logic [2:0]      head_dest;

   // Round-robin state
   logic [2:0]      ptr;
   logic [8:0]      bcnt;
   logic            mode_q;

   // Round-robin decision for the current pop
   logic [2:0]      rr_sel;
   logic [2:0]      rr_ptr_next;
   logic [8:0]      bcnt_eff;
   logic [8:0]      rr_bcnt_next;

   // Next enabled channel strictly after 'from', wrapping 7->0; if no other
   // channel is enabled the search lands back on 'from' itself.
   function automatic logic [2:0] next_enabled(input logic [2:0] from,
                                               input logic [7:0] mask);
      logic [2:0] found;
      logic [2:0] cand;
      found = from;
      // walk from the farthest offset down so the nearest enabled one wins
      for (int i = 7; i >= 1; i--) begin
         cand = from + 3'(i);
         if (mask[cand]) begin
            found = cand;
         end
      end
      return found;
   endfunction

   // Saturating 8-bit increment for the drop counter
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

   assign head_data = mem[rd_ptr][DATA_WIDTH-1:0];
   assign head_dest = mem[rd_ptr][EW-1:DATA_WIDTH];

   // ready is a registered !full, so a push never targets a full FIFO
   assign push   = in_valid_i && in_ready_o;
   // the FSM leaves IDLE exactly when the FIFO holds a word; a pop also needs
   // either directed mode or at least one enabled channel
   assign pop    = (state != IDLE) && (mode_i || (chan_en_i != 8'h00));
   assign busy_o = (count != '0);

   // Occupancy after this edge
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (!push && pop) begin
         count_next = count - CW'(1);
      end
   end

   // Channel choice and burst bookkeeping for a round-robin pop
   always_comb begin
      bcnt_eff = (mode_i != mode_q) ? 9'd0 : bcnt;
      rr_sel   = ptr;
      if (!chan_en_i[ptr]) begin
         rr_sel   = next_enabled(ptr, chan_en_i);
         bcnt_eff = 9'd0;
      end
      if (bcnt_eff + 9'd1 == BURST_MAX) begin
         rr_ptr_next  = next_enabled(rr_sel, chan_en_i);
         rr_bcnt_next = 9'd0;
      end else begin
         rr_ptr_next  = rr_sel;
         rr_bcnt_next = bcnt_eff + 9'd1;
      end
   end

   // FIFO storage write; contents need no reset since count gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {in_dest_i, in_data_i};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
      end
   end

   // Registered ready: no bypass, so a pop on a full FIFO frees space next cycle
   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         in_ready_o <= 1'b0;
      end else begin
         in_ready_o <= (count_next != FULL_CNT);
      end
   end

   // Dispatch FSM: state, round-robin pointer/burst count and demux outputs
   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         state      <= IDLE;
         ptr        <= 3'd0;
         bcnt       <= 9'd0;
         mode_q     <= 1'b0;
         selector_o <= 3'd0;
         channel_o  <= '0;
         strobe_o   <= 1'b0;
      end else begin
         mode_q    <= mode_i;
         strobe_o  <= 1'b0;
         channel_o <= '0;
         if (mode_i != mode_q) begin
            bcnt <= 9'd0;
         end
         if (pop) begin
            if (!mode_i) begin
               ptr        <= rr_ptr_next;
               bcnt       <= rr_bcnt_next;
               selector_o <= rr_sel;
               channel_o  <= head_data;
               strobe_o   <= 1'b1;
            end else if (chan_en_i[head_dest]) begin
               selector_o <= head_dest;
               channel_o  <= head_data;
               strobe_o   <= 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (push) begin
                  state <= RUN;
               end
            end
            RUN, STALL: begin
               if (count_next == '0) begin
                  state <= IDLE;
               end else if (!mode_i && (chan_en_i == 8'h00)) begin
                  state <= STALL;
               end else begin
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DEMUX_DISPATCH_DROP_CNT_EN
   logic drop;

   assign drop = pop && mode_i && !chan_en_i[head_dest];

   // Count words discarded because their destination channel is disabled
   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         drop_cnt_o <= 8'd0;
      end else if (drop) begin
         drop_cnt_o <= sat_inc8(drop_cnt_o);
      end
   end
`else
   assign drop_cnt_o = 8'd0;
`endif

endmodule

// File: doc/demux_dispatcher.md
# demux_dispatcher

Upstream feeder for the 8-way output demultiplexer. Accepts data words from a source over a valid/ready handshake, buffers them in a small FIFO and issues one word per cycle with a 3-bit channel select. The channel is chosen either by round-robin bursts over enabled channels or by a per-word destination tag. The `selector_o`/`channel_o` pair drives the demux `selector_i`/`channel_in_i` inputs directly.

## Interface
- `DATA_WIDTH`, 32, word width; matches the demux channel width.
- `FIFO_DEPTH`, 4, input buffer entries; power of two, ≥2.
- `BURST_LEN`, 4, words sent to one channel before round-robin advances; 1..256.

- `clk_i` in 1: single clock, rising edge.
- `arstn_i` in 1: reset, synchronous, active-low.
- `in_valid_i` in 1: source word valid.
- `in_ready_o` out 1: block can accept a word.
- `in_data_i` in DATA_WIDTH: source word.
- `in_dest_i` in 3: destination tag, used in directed mode only.
- `mode_i` in 1: 0 = round-robin, 1 = directed.
- `chan_en_i` in 8: per-channel enable mask; bit n enables selector value n.
- `selector_o` out 3: channel select to the demux.
- `channel_o` out DATA_WIDTH: word to the demux.
- `strobe_o` out 1: `channel_o` carries a valid word this cycle.
- `busy_o` out 1: FIFO non-empty.
- `drop_cnt_o` out 8: dropped-word counter (see Configuration).

## Operation
- **Push:** a word is pushed when `in_valid_i && in_ready_o`; {data, dest} is stored together.
- **Ready:** `in_ready_o` is registered and equals !full for the next cycle. When the FIFO is full, ready is 0, even if a pop happens in the same cycle. No bypass path.
- **FSM states:**
  - IDLE: FIFO empty.
  - RUN: FIFO non-empty and a pop is possible.
  - STALL: round-robin mode and `chan_en_i == 0`.
- **FSM transitions:**
  - IDLE→RUN on first push.
  - RUN→IDLE when the last entry pops with no push.
  - RUN↔STALL follows the mask in round-robin mode.
  - STALL→RUN also occurs when `mode_i` goes to 1.
- **Round-robin mode:**
  - Internal pointer `ptr` (reset 0) and burst counter `bcnt` (reset 0).
  - A pop sends the head word with `selector_o = ptr`, `strobe_o = 1`; `bcnt` increments.
  - When `bcnt` reaches BURST_LEN, `ptr` moves to the next enabled channel, searching `ptr`+1 upward with wrap 7→0, and `bcnt` is cleared.
  - If `ptr` is disabled at pop time, `ptr` first moves to the next enabled channel and `bcnt` clears; the word goes to the new channel in the same cycle.
  - If exactly one channel is enabled, `ptr` stays on it.
  - `in_dest_i` is ignored.
- **Directed mode:**
  - Each pop uses the stored dest.
  - If `chan_en_i[dest]` is set: `selector_o = dest`, `strobe_o = 1`.
  - Otherwise the word is discarded: `strobe_o = 0` and `drop_cnt_o` increments, saturating at 255.
- **Mode change:** any change of `mode_i` clears `bcnt`. `ptr` is retained.
- **Output defaults:** when `strobe_o = 0`, `channel_o` = 0 and `selector_o` holds its last value, so the demux sees zero data on the held channel.
- **`busy_o`:** equals FIFO count != 0.

## Timing
- Word accepted at edge k is eligible to pop at edge k+1; with `strobe_o = 1` it is visible after edge k+1, i.e. one-cycle latency.
- Throughput: one word per cycle sustained with `in_valid_i` held high and FIFO_DEPTH ≥ 2.
- Pops happen every cycle while in RUN; there is no downstream backpressure.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- `chan_en_i` and `mode_i` are sampled at the pop edge.
- **Reset:** while `arstn_i` is low at an edge, all of the following are cleared:
  - FIFO count and pointers;
  - `ptr`, `bcnt`, FSM (to IDLE);
  - `selector_o` = 0, `channel_o` = 0, `strobe_o` = 0, `busy_o` = 0, `drop_cnt_o` = 0, `in_ready_o` = 0.
- In-flight words are lost on reset. `in_ready_o` returns to 1 at the first edge with `arstn_i` high.

## Configuration
- **Macro:** `DEMUX_DISPATCH_DROP_CNT_EN`.
- **Defined:** `drop_cnt_o` is an 8-bit saturating counter as described in Operation.
- **Undefined:**
  - The counter logic is not built and `drop_cnt_o` is tied to 0.
  - Directed-mode drops still occur, with `strobe_o = 0`.

## Test plan
- **Reset release:** hold `arstn_i` = 0 for 3 cycles with `in_valid_i` = 1, then release.
  - All outputs are 0 during reset.
  - `in_ready_o` = 1 after the first edge with reset high.
  - No strobe until a word has been accepted.
- **Round-robin bursts:** `mode_i` = 0, `chan_en_i` = 8'hFF, BURST_LEN = 4, stream 0x00..0x0B back-to-back.
  - Selectors are 0,0,0,0,1,1,1,1,2,2,2,2, strobe continuous.
  - First strobe one cycle after the first accept.
- **Sparse mask and stall:** `chan_en_i` = 8'b1000_0010 gives selector sequence 1×4, 7×4, 1×4. Then set mask to 0 with 4 words queued.
  - FSM in STALL, FIFO fills, `in_ready_o` = 0, no strobes.
  - Restoring mask 8'h01 drains to selector 0.
- **Directed drop:** `mode_i` = 1, mask 8'h0F, dests 2,5,3,7 with data 0xA,0xB,0xC,0xD.
  - Strobes only for 0xA on sel 2 and 0xC on sel 3.
  - `drop_cnt_o` = 2, or 0 with the macro undefined.
- **Full FIFO:** hold `in_valid_i` high with mask 0 in round-robin mode.
  - Exactly FIFO_DEPTH words accepted and `in_ready_o` drops.
  - Enable a channel: one pop per cycle; ready returns one cycle after the first pop; no word lost or duplicated.
- **Mid-operation reset:** assert reset mid-burst with 3 words queued.
  - FIFO empties, `ptr` = 0, the next burst starts at channel 0 with a full BURST_LEN.
